// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
// Optional MMIO window is enabled with DMEM_MMIO_EN.
package dmem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_WAIT,
    DONE,
    MMIO_WAIT
  } state_t;

  localparam logic [15:0] MMIO_BASE_HI = 16'hFFFF;

  localparam logic [3:0] WE_B = 4'b0001;
  localparam logic [3:0] WE_H = 4'b0011;
  localparam logic [3:0] WE_W = 4'b1111;

  localparam int ERR_REQ = 0;
  localparam int ERR_OVR = 1;

endpackage

// File: rtl/dmem_if.sv
// Core-side request/response bundle of the data-memory controller.
// The core is the master, the controller the slave.
interface dmem_if;
  logic        req_load;
  logic [3:0]  req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rsp_rdata;
  logic        rsp_done;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_load, req_we, req_addr, req_wdata,
    input  rsp_rdata, rsp_done, rsp_err, busy
  );

  modport slave (
    input  req_load, req_we, req_addr, req_wdata,
    output rsp_rdata, rsp_done, rsp_err, busy
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store mask/data shift, load rotate,
// and detection of stores that would straddle a word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  input  logic [1:0]  wr_off,
  input  logic [31:0] rdata,
  input  logic [1:0]  rd_off,
  output logic [3:0]  we_sh,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_rot,
  output logic        misalign
);

  logic [63:0] rd_dbl;

  assign we_sh    = we << wr_off;
  assign wdata_sh = wdata << {wr_off, 3'b000};
  assign rd_dbl   = {rdata, rdata} >> {rd_off, 3'b000};
  assign rdata_rot = rd_dbl[31:0];

  always_comb begin
    misalign = 1'b0;
    unique case (1'b1)
      (we == WE_H): misalign = (wr_off == 2'd3);
      (we == WE_W): misalign = (wr_off != 2'd0);
      default:      misalign = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller between the core memory stage and a BRAM.
// Define DMEM_MMIO_EN to route 0xFFFF_xxxx to the MMIO port.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int BRAM_LAT = 2
) (
  input  logic              clk,
  input  logic              rstn,
  dmem_if.slave             bus,
  output logic [1:0]        err_sticky,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wdata,
  input  logic [31:0]       bram_rdata,
  output logic              mmio_req,
  output logic [3:0]        mmio_we,
  output logic [15:0]       mmio_addr,
  output logic [31:0]       mmio_wdata,
  input  logic [31:0]       mmio_rdata,
  input  logic              mmio_ack
);

  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic r_load, r_err;
  logic [3:0] r_we;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0] r_wdata, rdata_q;
  logic [1:0] sticky;
  logic strobe, conflict, misal, bad;
  logic win, accept, rd_last, mmio_go;
  logic [3:0] we_sh;
  logic [31:0] wdata_sh, rd_src, rd_rot;
  logic unused_in;

  assign strobe   = bus.req_load | (|bus.req_we);
  assign conflict = bus.req_load & (|bus.req_we);
  assign bad      = conflict | misal;
  assign accept   = strobe & (state == IDLE);
  assign rd_last  = (state == RD_WAIT)
                  & (cnt == 3'(BRAM_LAT - 1));

`ifdef DMEM_MMIO_EN
  assign win     = (bus.req_addr[31:16] == MMIO_BASE_HI);
  assign mmio_go = mmio_ack;
  assign rd_src  = (state == MMIO_WAIT) ? mmio_rdata
                                        : bram_rdata;
`else
  assign win     = 1'b0;
  assign mmio_go = 1'b0;
  assign rd_src  = bram_rdata;
`endif

  assign unused_in = ^{mmio_rdata, mmio_ack,
                       bus.req_addr[31:ADDR_W+2]};

  dmem_lane_align u_align (
    .we       (bus.req_we),
    .wdata    (bus.req_wdata),
    .wr_off   (bus.req_addr[1:0]),
    .rdata    (rd_src),
    .rd_off   (r_addr[1:0]),
    .we_sh    (we_sh),
    .wdata_sh (wdata_sh),
    .rdata_rot(rd_rot),
    .misalign (misal)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      r_load  <= 1'b0;
      r_err   <= 1'b0;
      r_we    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      rdata_q <= '0;
      sticky  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        r_load  <= bus.req_load & ~bad;
        r_err   <= bad;
        r_we    <= bad ? 4'b0000 : we_sh;
        r_addr  <= bus.req_addr[ADDR_W+1:0];
        r_wdata <= wdata_sh;
        if (bad) sticky[ERR_REQ] <= 1'b1;
      end
      if (strobe && state != IDLE)
        sticky[ERR_OVR] <= 1'b1;
      if (rd_last ||
          (state == MMIO_WAIT && mmio_go && r_load))
        rdata_q <= rd_rot;
    end
  end

  // Rejected requests still pass through WR (write
  // suppressed) so every store-shaped op completes alike.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (bad)               state_n = WR;
          else if (win)          state_n = MMIO_WAIT;
          else if (bus.req_load) state_n = RD_ISSUE;
          else                   state_n = WR;
        end
      end
      WR: state_n = DONE;
      RD_ISSUE: begin
        state_n = RD_WAIT;
        cnt_n   = '0;
      end
      RD_WAIT: begin
        if (rd_last) state_n = DONE;
        else         cnt_n   = cnt + 3'd1;
      end
      MMIO_WAIT: if (mmio_go) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bram_en    = 1'b0;
    bram_we    = 4'b0000;
    mmio_req   = 1'b0;
    mmio_we    = 4'b0000;
    mmio_addr  = 16'h0000;
    mmio_wdata = 32'h0;
    unique case (state)
      WR: begin
        bram_en = ~r_err;
        bram_we = r_we;
      end
      RD_ISSUE: bram_en = 1'b1;
`ifdef DMEM_MMIO_EN
      MMIO_WAIT: begin
        mmio_req   = 1'b1;
        mmio_we    = r_we;
        mmio_addr  = r_addr[15:0];
        mmio_wdata = r_wdata;
      end
`endif
      default: ;
    endcase
  end

  assign bram_addr     = r_addr[ADDR_W+1:2];
  assign bram_wdata    = r_wdata;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_done  = (state == DONE);
  assign bus.rsp_err   = (state == DONE) & r_err;
  assign bus.busy      = (state != IDLE);
  assign err_sticky    = sticky;

endmodule
